// File: rtl/prime_store_playback.sv
// prime_store_playback
// Capture-and-replay buffer placed after the prime-number checker. While a ROM
// scan runs, every value flagged prime is stored in arrival order in a 2^N x M
// memory. Once the scan is done, the stored primes are stepped through on a
// slow tick, wrapping, to feed the seven-segment display mux.
//
// Optional build macro: PRIME_DEDUP_EN. When defined, a prime equal to the
// most recently stored entry is discarded during capture.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   clr_buf    in   synchronous clear: empty the buffer and return to CAPTURE
//   wr_valid   in   one-cycle strobe: checker result available
//   wr_prime   in   checker PRIME flag, qualified by wr_valid
//   wr_data    in   [M-1:0] value that was tested, qualified by wr_valid
//   scan_done  in   level: the ROM scan is complete
//   tick       in   one-cycle playback advance strobe
//   disp_addr  out  [N-1:0] index of the entry being shown
//   disp_data  out  [M-1:0] stored prime at disp_addr (one cycle behind it)
//   disp_valid out  disp_data is meaningful (high while in PLAY)
//   count      out  [N:0] number of stored entries, 0..2^N
//   full       out  count == 2^N
//   overflow   out  sticky: a prime was dropped because the buffer was full
//   state      out  [1:0] 00 CAPTURE, 01 PLAY, 10 EMPTY
module prime_store_playback #(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_buf,
    input  logic         wr_valid,
    input  logic         wr_prime,
    input  logic [M-1:0] wr_data,
    input  logic         scan_done,
    input  logic         tick,
    output logic [N-1:0] disp_addr,
    output logic [M-1:0] disp_data,
    output logic         disp_valid,
    output logic [N:0]   count,
    output logic         full,
    output logic         overflow,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'b00,
        ST_PLAY    = 2'b01,
        ST_EMPTY   = 2'b10
    } state_t;

    localparam logic [N:0]   CAP_C      = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   ONE_C      = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   CNT_ZERO_C = {(N+1){1'b0}};
    localparam logic [N-1:0] ADDR_ZERO_C = {N{1'b0}};
    localparam logic [N-1:0] ADDR_ONE_C = {{(N-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] DATA_ZERO_C = {M{1'b0}};

    state_t         state_r;
    logic [N:0]     count_r;
    logic [N-1:0]   disp_addr_r;
    logic [M-1:0]   disp_data_r;
    logic           disp_valid_r;
    logic           full_r;
    logic           overflow_r;
    logic [M-1:0]   mem_r [2**N];

    logic           prime_s;
    logic           dup_s;
    logic           store_s;
    logic           drop_s;
    logic [N:0]     count_nxt_s;
    logic           wrap_s;

`ifdef PRIME_DEDUP_EN
    logic [M-1:0]   last_r;
    logic           last_vld_r;
`endif

    // Classify the incoming checker result and compute the post-write count
    always_comb begin
        prime_s = wr_valid && wr_prime && (state_r == ST_CAPTURE);
`ifdef PRIME_DEDUP_EN
        dup_s = last_vld_r && (wr_data == last_r);
`else
        dup_s = 1'b0;
`endif
        // A duplicate is discarded before the full check, so it never sets overflow
        store_s = prime_s && !dup_s && !full_r;
        drop_s  = prime_s && !dup_s && full_r;
        if (store_s) begin
            count_nxt_s = count_r + ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
        wrap_s = ({1'b0, disp_addr_r} == (count_r - ONE_C));
    end

    // Storage array: written at the current fill level, contents never reset
    always_ff @(posedge clk) begin
        if (store_s && !clr_buf) begin
            mem_r[count_r[N-1:0]] <= wr_data;
        end
    end

`ifdef PRIME_DEDUP_EN
    // Remember the most recently stored value for duplicate suppression
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r     <= DATA_ZERO_C;
            last_vld_r <= 1'b0;
        end else if (clr_buf) begin
            last_r     <= DATA_ZERO_C;
            last_vld_r <= 1'b0;
        end else if (store_s) begin
            last_r     <= wr_data;
            last_vld_r <= 1'b1;
        end
    end
`endif

    // Control FSM, fill counter and registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_CAPTURE;
            count_r      <= CNT_ZERO_C;
            disp_addr_r  <= ADDR_ZERO_C;
            disp_data_r  <= DATA_ZERO_C;
            disp_valid_r <= 1'b0;
            full_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (clr_buf) begin
            state_r      <= ST_CAPTURE;
            count_r      <= CNT_ZERO_C;
            disp_addr_r  <= ADDR_ZERO_C;
            disp_data_r  <= DATA_ZERO_C;
            disp_valid_r <= 1'b0;
            full_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            // Synchronous read: data follows the address one cycle later,
            // and is forced to zero whenever we are not playing back
            disp_valid_r <= (state_r == ST_PLAY);
            if (state_r == ST_PLAY) begin
                disp_data_r <= mem_r[disp_addr_r];
            end else begin
                disp_data_r <= DATA_ZERO_C;
            end

            case (state_r)
                ST_CAPTURE: begin
                    count_r <= count_nxt_s;
                    full_r  <= (count_nxt_s == CAP_C);
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                    end
                    // The transition sees the count including a same-cycle write
                    if (scan_done) begin
                        disp_addr_r <= ADDR_ZERO_C;
                        if (count_nxt_s != CNT_ZERO_C) begin
                            state_r <= ST_PLAY;
                        end else begin
                            state_r <= ST_EMPTY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (wrap_s) begin
                            disp_addr_r <= ADDR_ZERO_C;
                        end else begin
                            disp_addr_r <= disp_addr_r + ADDR_ONE_C;
                        end
                    end
                end
                ST_EMPTY: begin
                    state_r <= ST_EMPTY;
                end
                default: begin
                    // Unreachable encoding: recover to a safe empty capture
                    state_r     <= ST_CAPTURE;
                    count_r     <= CNT_ZERO_C;
                    full_r      <= 1'b0;
                    disp_addr_r <= ADDR_ZERO_C;
                end
            endcase
        end
    end

    assign disp_addr  = disp_addr_r;
    assign disp_data  = disp_data_r;
    assign disp_valid = disp_valid_r;
    assign count      = count_r;
    assign full       = full_r;
    assign overflow   = overflow_r;
    assign state      = state_r;

endmodule

// File: tb/tb_prime_store_playback.sv
// Self-checking bench for prime_store_playback: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based behavioural model.
module tb_prime_store_playback;

    logic       clk;
    logic       reset_n;
    logic       clr_buf;
    logic       wr_valid;
    logic       wr_prime;
    logic [7:0] wr_data;
    logic       scan_done;
    logic       tick;
    logic [3:0] disp_addr;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [1:0] state;

    int n_total = 0;
    int n_pass  = 0;
    bit run_cmp = 0;

    // Behavioural model: stored primes as a queue, mode 0 capture / 1 play / 2 empty
    logic [7:0] q[$];
    int         m_mode;
    int         m_idx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovf;

    prime_store_playback #(.N(4), .M(8)) dut (
        .clk(clk), .reset_n(reset_n), .clr_buf(clr_buf), .wr_valid(wr_valid),
        .wr_prime(wr_prime), .wr_data(wr_data), .scan_done(scan_done), .tick(tick),
        .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .count(count), .full(full), .overflow(overflow), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode  = 0;
        m_idx   = 0;
        m_data  = 8'd0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        logic       nv;
        logic [7:0] nd;
        bit         dup;
        nv = (m_mode == 1) && !clr_buf;
        nd = nv ? q[m_idx] : 8'd0;
        if (clr_buf) begin
            q.delete();
            m_mode = 0;
            m_idx  = 0;
            m_ovf  = 1'b0;
        end else if (m_mode == 0) begin
            if (wr_valid && wr_prime) begin
                dup = 0;
`ifdef PRIME_DEDUP_EN
                dup = (q.size() > 0) && (q[q.size()-1] == wr_data);
`endif
                if (!dup) begin
                    if (q.size() == 16) m_ovf = 1'b1;
                    else q.push_back(wr_data);
                end
            end
            if (scan_done) begin
                m_mode = (q.size() > 0) ? 1 : 2;
                m_idx  = 0;
            end
        end else if (m_mode == 1) begin
            if (tick) m_idx = (m_idx + 1) % q.size();
        end
        m_valid = nv;
        m_data  = nd;
    endtask

    task automatic step(input logic c, input logic wv, input logic wp,
                        input logic [7:0] wd, input logic sd, input logic tk);
        @(negedge clk);
        clr_buf   = c;
        wr_valid  = wv;
        wr_prime  = wp;
        wr_data   = wd;
        scan_done = sd;
        tick      = tk;
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic prime(input logic [7:0] v);
        step(1'b0, 1'b1, 1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_addr"}, 32'(disp_addr), 32'd0);
        chk({tag, "_data"}, 32'(disp_data), 32'd0);
        chk({tag, "_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (run_cmp && reset_n) begin
            chk("state", 32'(state), 32'(m_mode));
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == 16));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("disp_addr", 32'(disp_addr), 32'(m_idx));
            chk("disp_valid", 32'(disp_valid), 32'(m_valid));
            chk("disp_data", 32'(disp_data), 32'(m_data));
        end
    end

    initial begin
        int seq1[4];
        seq1 = '{3, 5, 7, 2};
        reset_n = 1'b0; clr_buf = 1'b0; wr_valid = 1'b0; wr_prime = 1'b0;
        wr_data = 8'd0; scan_done = 1'b0; tick = 1'b0;
        model_reset();
        #3;
        chk_all_zero("reset");
        #9;
        reset_n = 1'b1;
        run_cmp = 1;

        // Basic capture and playback
        prime(8'd2); prime(8'd3); prime(8'd5); prime(8'd7);
        step(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("t1_count", 32'(count), 32'd4);
        chk("t1_state", 32'(state), 32'd1);
        idle();
        chk("t1_valid", 32'(disp_valid), 32'd1);
        chk("t1_data0", 32'(disp_data), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
            idle();
            chk("t1_seq", 32'(disp_data), 32'(seq1[k]));
        end

        // Clear issued together with a write
        step(1'b1, 1'b1, 1'b1, 8'd13, 1'b0, 1'b0);
        chk("clr_wr_count", 32'(count), 32'd0);
        chk("clr_wr_state", 32'(state), 32'd0);

        // Overfill with 17 distinct values, then wrap-around playback
        for (int i = 0; i < 17; i++) prime(8'(i * 13 + 1));
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
            idle();
        end
        chk("wrap_addr", 32'(disp_addr), 32'd0);
        chk("wrap_data", 32'(disp_data), 32'd1);

        // Empty scan
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("empty_state", 32'(state), 32'd2);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("empty_valid", 32'(disp_valid), 32'd0);
        chk("empty_data", 32'(disp_data), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("empty_clr_state", 32'(state), 32'd0);

        // Write coinciding with scan_done on an empty buffer
        step(1'b0, 1'b1, 1'b1, 8'd11, 1'b1, 1'b0);
        chk("same_cnt", 32'(count), 32'd1);
        chk("same_state", 32'(state), 32'd1);
        idle();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
            idle();
            chk("single_data", 32'(disp_data), 32'd11);
            chk("single_addr", 32'(disp_addr), 32'd0);
        end

        // Asynchronous reset between clock edges while playing
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        #2;
        reset_n = 1'b1;

        // Repeated primes
        prime(8'd3); prime(8'd3); prime(8'd5); prime(8'd5); prime(8'd3);
`ifdef PRIME_DEDUP_EN
        chk("dedup_count", 32'(count), 32'd3);
`else
        chk("dedup_count", 32'(count), 32'd5);
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                 8'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prime_store_playback.md
# prime_store_playback

Capture-and-replay buffer that sits directly downstream of the prime-number checker. During a ROM scan it stores every value flagged prime into an internal 2^N x M memory, in arrival order. When the scan finishes it steps through the stored primes on a slow tick, wrapping, and drives an address/data pair for the seven-segment display mux.

## Interface
- N, 4, address width; capacity 2^N entries
- M, 8, data width of stored values
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr_buf  in  1  synchronous clear: empty buffer, return to CAPTURE
- wr_valid  in  1  one-cycle strobe: checker result available (checker DONE edge)
- wr_prime  in  1  checker PRIME flag, qualified by wr_valid
- wr_data  in  M  number just tested, qualified by wr_valid
- scan_done  in  1  level: ROM scan complete (counter rco)
- tick  in  1  one-cycle playback advance strobe (slow-clock enable)
- disp_addr  out  N  index of entry currently shown
- disp_data  out  M  stored prime at disp_addr
- disp_valid  out  1  disp_data is meaningful
- count  out  N+1  number of stored entries, 0..2^N
- full  out  1  count == 2^N
- overflow  out  1  sticky: a prime was dropped because the buffer was full
- state  out  2  00 CAPTURE, 01 PLAY, 10 EMPTY

## Operation
- Reset (reset_n=0, asynchronous): state=CAPTURE, count=0, disp_addr=0, disp_data=0, disp_valid=0, full=0, overflow=0. Memory contents are not reset.
- CAPTURE:
  - wr_valid && wr_prime && !full: mem[count[N-1:0]] <= wr_data; count++.
  - wr_valid && wr_prime && full: no write; overflow <= 1.
  - wr_valid && !wr_prime: ignored.
  - tick is ignored in this state.
- CAPTURE -> PLAY: on scan_done=1 when the post-write count > 0. disp_addr <= 0.
- CAPTURE -> EMPTY: on scan_done=1 when the post-write count == 0.
- Simultaneous wr_valid and scan_done in the same cycle: the write is committed first, and the transition evaluates the updated count.
- PLAY:
  - On tick: if disp_addr == count-1 then disp_addr <= 0, else disp_addr++.
  - With count == 1, disp_addr stays at 0.
  - wr_valid is ignored.
- EMPTY: disp_valid=0 and disp_data=0. Remains here until clr_buf or reset.
- clr_buf (any state): next cycle state=CAPTURE, count=0, disp_addr=0, disp_valid=0, overflow=0. clr_buf has priority over a write and over scan_done in the same cycle.
- Arithmetic:
  - count is N+1 bits and never exceeds 2^N.
  - disp_addr is N bits and is always < count in PLAY.

## Timing
- Write latency: the entry is in memory, and count is updated, on the edge that samples wr_valid.
- Memory read is synchronous. disp_data reflects mem[disp_addr] one cycle after disp_addr changes.
- disp_valid rises one cycle after entering PLAY and stays high for as long as the block is in PLAY.
- full and state are registered outputs with no combinational input-to-output paths.
- tick is expected no more than once every 2 clk cycles. Back-to-back ticks still advance disp_addr each cycle, and disp_data lags by one cycle.
- If reset_n is asserted mid-operation, all outputs go to their reset values immediately, independent of clk.

## Configuration
- PRIME_DEDUP_EN defined: in CAPTURE, a qualifying prime whose wr_data equals the most recently stored entry is discarded. count does not change and overflow is not set. The last-stored register clears on reset and clr_buf, and the first prime after a clear is always stored.
- PRIME_DEDUP_EN undefined: every qualifying prime is stored, including repeats.

## Test plan
- After reset, primes 2,3,5,7 written, non-prime 4 written, then scan_done -> count=4, state=PLAY, disp_data sequence 2,3,5,7,2 on successive ticks, disp_valid=1.
- 17 primes written with N=4 -> count=16, full=1, overflow=1, 17th value absent; playback wraps from disp_addr 15 to 0.
- scan_done with no primes written -> state=EMPTY, disp_valid=0, disp_data=0; then clr_buf -> state=CAPTURE.
- wr_valid/wr_prime with data 11 asserted in the same cycle as scan_done, on an empty buffer -> count=1, state=PLAY, disp_data=11 held across ticks.
- reset_n pulsed low during PLAY between clock edges -> all outputs zero before the next edge; clr_buf issued together with a write -> count=0.
- PRIME_DEDUP_EN defined, writes 3,3,5,5,3 -> stored sequence 3,5,3, count=3; without the macro -> count=5.
